instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Instruction-side responder for the Mips32 core. It receives a program as a valid/ready word stream, writes it into an internal instruction memory, and holds the core in reset until loading completes. It then serves the core's combinational fetch reads (`raddr` → `instr`) and watches `halted` to report run completion and the cycle count. It replaces the static `initial`-block program image in the test top with a loadable one.

## Interface
- `ADDR_SIZE`, 8: log2 of instruction memory depth in words.
- `RESET_CYCLES`, 3: number of cycles the core is held in reset after load, valid range 1..15.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: a program word is present on `load_data`.
- `load_ready` out 1: the block accepts a word this cycle.
- `load_data` in 32: program word.
- `load_last` in 1: qualifies the final word of the program.
- `restart` in 1: request a new load; honoured only in DONE.
- `fetch_addr` in 32: word address, connected to the core's `raddr`.
- `fetch_data` out 32: instruction, connected to the core's `instr`.
- `core_reset` out 1: active-high reset to the core.
- `core_halted` in 1: the core's `halted` output.
- `run_done` out 1: the program has halted.
- `word_count` out ADDR_SIZE+1: number of words loaded.
- `cycle_count` out 32: number of RUN-state cycles.
- `fetch_fault` out 1: sticky out-of-range fetch flag; driven to 0 unless `IMEM_LOADER_BOUNDS_CHECK_EN` is defined.

## Operation
- States are LOAD, HOLD, RUN and DONE.
- Reset values, with asynchronous clear:
  - state = LOAD, write pointer = 0, hold counter = 0.
  - `word_count` = 0, `cycle_count` = 0.
  - `run_done` = 0, `fetch_fault` = 0.
  - `core_reset` = 1, `load_ready` = 1.
  - Memory contents are not reset.
- LOAD:
  - `load_ready` = 1.
  - Each accept (`load_valid & load_ready`) writes `mem[wptr] <= load_data` and increments `wptr` and `word_count`.
  - The block goes to HOLD when the accepted word has `load_last=1`, or when it lands at index 2**ADDR_SIZE−1 (memory full). The full case does not wait for `load_last`.
  - `load_valid` with no accept is a no-op.
- HOLD:
  - `load_ready` = 0 and `core_reset` = 1.
  - The hold counter counts up to RESET_CYCLES, then the block goes to RUN.
  - `core_halted` is ignored in this state.
- RUN:
  - `core_reset` = 0.
  - `cycle_count` increments on every RUN edge and saturates at 32'hFFFFFFFF.
  - When `core_halted` is sampled at 1, the block goes to DONE, the counter increments for that edge, and `run_done` is set.
- DONE:
  - `core_reset` = 1, `run_done` = 1, counters frozen.
  - `restart=1` returns the block to LOAD and clears `wptr`, `word_count`, `cycle_count`, `run_done` and `fetch_fault`.
  - `restart` is ignored in all other states.
- Fetch:
  - `fetch_data = mem[fetch_addr[ADDR_SIZE-1:0]]`, a combinational read available in every state.
  - A write and a read of the same index in the same cycle return the old word.
- Arithmetic:
  - `wptr` is ADDR_SIZE bits.
  - `word_count` is ADDR_SIZE+1 bits, so a full load reports 2**ADDR_SIZE.

## Timing
- Load: one word per cycle, zero wait. `load_ready` is a registered state decode.
- After the final accept, `load_ready` is 0 on the next cycle.
- `core_reset` stays high for exactly RESET_CYCLES cycles after the final accept edge, then falls.
- Halt: `run_done` rises one cycle after `core_halted` is first sampled high in RUN. `core_reset` rises in the same cycle.
- Fetch latency is 0 cycles; there are no fetch-path registers.
- Asserting `reset_n` low mid-load or mid-run immediately forces the reset values. Words already written remain in memory but `word_count` reads 0.

## Configuration
- Macro: `IMEM_LOADER_BOUNDS_CHECK_EN`.
- Defined:
  - A fetch with `fetch_addr >= word_count` returns 32'h0000000D (break), so the core halts instead of executing stale memory.
  - In RUN, such a fetch also sets `fetch_fault` at the next edge; the flag is sticky until reset or restart.
- Undefined:
  - The address is truncated to ADDR_SIZE bits and the memory contents are returned.
  - `fetch_fault` is tied to 0.

## Test plan
- **Sum program:** stream the 9 sum-program words (0x00631826 … 0x0040000D) with `load_last` on the 9th.
  - `word_count` = 9.
  - `core_reset` falls 3 cycles after the final accept.
  - The core halts with register 2 = 45, then `run_done` = 1.
- **Backpressure:** hold `load_valid=1` with junk data through HOLD and RUN.
  - No further accepts occur and `word_count` stays 9.
  - Memory entries at index ≥ 9 are unchanged.
- **Full memory:** with ADDR_SIZE=4, stream 20 words with no `load_last`.
  - Exactly 16 are accepted and `word_count` = 16.
  - `load_ready` is 0 from the cycle after the 16th accept.
- **Halt count:** drive `core_halted`=1 on the 40th RUN cycle.
  - `cycle_count` = 40 and `run_done` = 1 on the next cycle.
  - The count is still 40 ten cycles later.
  - `restart` pulsed in DONE returns to LOAD with all counters at 0.
- **Async reset:** pulse `reset_n` low for half a cycle after 4 of 9 words.
  - All outputs immediately take their reset values (`load_ready`=1, `core_reset`=1).
  - A full reload then runs correctly.
- **Bounds check** (macro defined): load 9 words, then force `fetch_addr`=12 in RUN.
  - `fetch_data` = 0x0000000D.
  - `fetch_fault` = 1 at the next edge and stays 1.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Program-load stream between a word source and instr_mem_loader.
//   load_valid : source has a program word on load_data
//   load_ready : loader accepts a word this cycle
//   load_data  : 32-bit program word
//   load_last  : marks the final word of the program
// Modports: master = word source, slave = loader.
interface instr_mem_loader_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction-side responder for the Mips32 core. Streams a program into an
// internal instruction memory, holds the core in reset until the load is done,
// serves combinational fetches and reports run completion with a cycle count.
//
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   load            : program word stream (instr_mem_loader_if.slave)
//   restart         : request a new load, honoured only once the run is done
//   fetch_addr/data : core fetch port (raddr -> instr), zero latency
//   core_reset      : active-high reset to the core
//   core_halted     : the core's halted output
//   run_done        : the program has halted
//   word_count      : number of words loaded (ADDR_SIZE+1 bits)
//   cycle_count     : number of RUN cycles, saturating
//   fetch_fault     : sticky out-of-range fetch flag
//
// Optional feature: define IMEM_LOADER_BOUNDS_CHECK_EN to return a break
// instruction (32'h0000000D) for fetches at or beyond word_count and to flag
// such fetches in RUN on fetch_fault. Without it fetch_fault is tied to 0.
module instr_mem_loader #(
  parameter int unsigned ADDR_SIZE    = 8,
  parameter int unsigned RESET_CYCLES = 3   // 1..15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  instr_mem_loader_if.slave    load,
  input  logic                 restart,
  input  logic [31:0]          fetch_addr,
  output logic [31:0]          fetch_data,
  output logic                 core_reset,
  input  logic                 core_halted,
  output logic                 run_done,
  output logic [ADDR_SIZE:0]   word_count,
  output logic [31:0]          cycle_count,
  output logic                 fetch_fault
);

  localparam int unsigned Depth    = 2 ** ADDR_SIZE;
  localparam logic [3:0]  HoldLast = 4'(RESET_CYCLES - 1);
  localparam logic [31:0] BreakOp  = 32'h0000000D;

  typedef enum logic [1:0] {StLoad, StHold, StRun, StDone} state_e;

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   wptr_q;
  logic [3:0]             hold_cnt_q;
  logic [ADDR_SIZE:0]     word_count_q;
  logic [31:0]            cycle_count_q;
  logic                   load_ready_q;
  logic                   core_reset_q;
  logic                   run_done_q;

  logic [31:0]            mem [Depth];
  logic                   accept;
  logic [31:0]            mem_word;

  // load_ready_q is only ever set while in LOAD, so it doubles as the state qualifier.
  assign accept   = load.load_valid & load_ready_q;
  assign mem_word = mem[fetch_addr[ADDR_SIZE-1:0]];

  // Memory is deliberately not reset; a reset only forgets how much was loaded.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wptr_q] <= load.load_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StLoad;
      wptr_q        <= '0;
      hold_cnt_q    <= '0;
      word_count_q  <= '0;
      cycle_count_q <= '0;
      load_ready_q  <= 1'b1;
      core_reset_q  <= 1'b1;
      run_done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            wptr_q       <= wptr_q + 1'b1;
            word_count_q <= word_count_q + 1'b1;
            // A full memory ends the load without waiting for load_last.
            if (load.load_last || (wptr_q == '1)) begin
              state_q      <= StHold;
              load_ready_q <= 1'b0;
              hold_cnt_q   <= '0;
            end
          end
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_q      <= StRun;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (cycle_count_q != '1) begin
            cycle_count_q <= cycle_count_q + 1'b1;
          end
          if (core_halted) begin
            state_q      <= StDone;
            run_done_q   <= 1'b1;
            core_reset_q <= 1'b1;
          end
        end
        StDone: begin
          if (restart) begin
            state_q       <= StLoad;
            wptr_q        <= '0;
            word_count_q  <= '0;
            cycle_count_q <= '0;
            run_done_q    <= 1'b0;
            load_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

`ifdef IMEM_LOADER_BOUNDS_CHECK_EN
  logic fetch_oob;
  logic fetch_fault_q;

  assign fetch_oob  = fetch_addr >= 32'(word_count_q);
  assign fetch_data = fetch_oob ? BreakOp : mem_word;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_fault_q <= 1'b0;
    end else if ((state_q == StDone) && restart) begin
      fetch_fault_q <= 1'b0;
    end else if ((state_q == StRun) && fetch_oob) begin
      fetch_fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fetch_fault_q;
`else
  // Upper address bits are intentionally ignored when bounds checking is off.
  logic unused_fetch_hi;
  logic [31:0] unused_break_op;

  assign unused_fetch_hi = ^fetch_addr[31:ADDR_SIZE];
  assign unused_break_op = BreakOp;
  assign fetch_data      = mem_word;
  assign fetch_fault     = 1'b0;
`endif

  assign load.load_ready = load_ready_q;
  assign core_reset      = core_reset_q;
  assign run_done        = run_done_q;
  assign word_count      = word_count_q;
  assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader (ADDR_SIZE=4, RESET_CYCLES=3).
// Run completions are checked by a scoreboard monitor; loads, hold timing,
// fetches and resets are checked against a behavioural model of the memory.
module tb_instr_mem_loader;

  localparam int unsigned Aw    = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned Rc    = 3;
`ifdef IMEM_LOADER_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          restart;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_data;
  logic          core_reset;
  logic          core_halted;
  logic          run_done;
  logic [Aw:0]   word_count;
  logic [31:0]   cycle_count;
  logic          fetch_fault;

  instr_mem_loader_if lif ();

  instr_mem_loader #(
    .ADDR_SIZE   (Aw),
    .RESET_CYCLES(Rc)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (lif),
    .restart    (restart),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .core_reset (core_reset),
    .core_halted(core_halted),
    .run_done   (run_done),
    .word_count (word_count),
    .cycle_count(cycle_count),
    .fetch_fault(fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned cycles;
    int unsigned words;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  int          mon_seen;

  // Behavioural model: memory image, words loaded, run cycles, fault flag.
  logic [31:0] ref_mem [Depth];
  int unsigned ref_wc;
  int unsigned ref_cc;
  bit          ref_fault;
  logic [31:0] stim [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
    logic [Aw-1:0] idx;
    idx = a[Aw-1:0];
    if (BoundsEn && (a >= ref_wc)) return 32'h0000000D;
    return ref_mem[idx];
  endfunction

  task automatic check_idle_load(input string tag);
    check({tag, "_load_ready"}, {31'd0, lif.load_ready}, 32'd1);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_run_done"}, {31'd0, run_done}, 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, 32'd0);
    check({tag, "_fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  // Streams up to n words from stim; the model accepts until last or full.
  task automatic load_program(input int n, input bit use_last, input bit gaps);
    int sent;
    bit done;
    sent = 0;
    done = 1'b0;
    while (!done && sent < n) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        lif.load_valid = 1'b0;
        lif.load_data  = $urandom;
        tick();
        check("gap_load_ready", {31'd0, lif.load_ready}, 32'd1);
        check("gap_word_count", 32'(word_count), ref_wc);
      end else begin
        lif.load_valid = 1'b1;
        lif.load_data  = stim[sent];
        lif.load_last  = use_last && (sent == n - 1);
        ref_mem[ref_wc[Aw-1:0]] = stim[sent];
        ref_wc++;
        done = lif.load_last || (ref_wc == Depth);
        sent++;
        tick();
        check("load_ready", {31'd0, lif.load_ready}, {31'd0, !done});
        check("load_word_count", 32'(word_count), ref_wc);
      end
    end
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
  endtask

  // Called on the cycle right after the final accept. Walks HOLD and RUN,
  // halting on RUN cycle n_run. junk keeps a word offered throughout.
  task automatic hold_and_run(input int n_run, input bit junk, input bit probe_oob);
    int seen0;
    for (int k = 0; k < int'(Rc); k++) begin
      check("hold_core_reset", {31'd0, core_reset}, 32'd1);
      check("hold_word_count", 32'(word_count), ref_wc);
      lif.load_valid = junk;
      lif.load_data  = $urandom;
      core_halted    = 1'($urandom_range(0, 1));
      restart        = ($urandom_range(0, 3) == 0);
      tick();
    end
    core_halted = 1'b0;
    seen0 = mon_seen;
    for (int c = 1; c <= n_run; c++) begin
      check("run_core_reset", {31'd0, core_reset}, 32'd0);
      check("run_run_done", {31'd0, run_done}, 32'd0);
      check("run_word_count", 32'(word_count), ref_wc);
      check("run_fetch_fault", {31'd0, fetch_fault}, {31'd0, ref_fault});
      if (probe_oob && c == 1) begin
        fetch_addr = 32'd12;
        #1;
        check("oob_fetch_data", fetch_data, exp_fetch(32'd12));
        if (BoundsEn) ref_fault = 1'b1;
      end else begin
        fetch_addr = $urandom_range(0, ref_wc - 1);
        #1;
        check("run_fetch_data", fetch_data, exp_fetch(fetch_addr));
      end
      lif.load_valid = junk;
      lif.load_data  = $urandom;
      restart        = ($urandom_range(0, 3) == 0);
      if (c == n_run) begin
        core_halted = 1'b1;
        ref_cc      = n_run;
        exp_q.push_back('{cycles: n_run, words: ref_wc});
      end
      tick();
      core_halted = 1'b0;
      restart     = 1'b0;
    end
    lif.load_valid = 1'b0;
    for (int w = 0; w < 4 && mon_seen == seen0; w++) begin
      @(negedge clock);
      #1;
    end
    if (mon_seen == seen0) begin
      checks++;
      errors++;
      $display("FAIL run_done_timeout: got no run_done required run_done=1");
    end
    tick();
    check("done_run_done", {31'd0, run_done}, 32'd1);
    check("done_core_reset", {31'd0, core_reset}, 32'd1);
    check("done_fetch_fault", {31'd0, fetch_fault}, {31'd0, ref_fault});
  endtask

  task automatic hold_done(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      lif.load_valid = 1'b1;
      lif.load_data  = $urandom;
      tick();
      check("frozen_cycle_count", cycle_count, ref_cc);
      check("frozen_word_count", 32'(word_count), ref_wc);
      check("frozen_load_ready", {31'd0, lif.load_ready}, 32'd0);
    end
    lif.load_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart   = 1'b0;
    ref_wc    = 0;
    ref_cc    = 0;
    ref_fault = 1'b0;
    check_idle_load("restart");
  endtask

  // Scoreboard monitor: pops one expectation per rising run_done.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = 1'b0;
      end else begin
        if (run_done && !prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got run_done=1 required no completion");
          end else begin
            e = exp_q.pop_front();
            check("sb_cycle_count", cycle_count, e.cycles);
            check("sb_word_count", 32'(word_count), e.words);
          end
          mon_seen++;
        end
        prev = run_done;
      end
    end
  end

  initial begin
    logic [31:0] sum_prog [9];
    sum_prog = '{32'h00631826, 32'h20630009, 32'h00421026, 32'h00431020,
                 32'h2063FFFF, 32'h1460FFFD, 32'h00000000, 32'hAC020000,
                 32'h0040000D};
    checks         = 0;
    errors         = 0;
    mon_seen       = 0;
    ref_wc         = 0;
    ref_cc         = 0;
    ref_fault      = 1'b0;
    reset_n        = 1'b0;
    restart        = 1'b0;
    fetch_addr     = '0;
    core_halted    = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_last  = 1'b0;
    #12;
    check_idle_load("reset");
    reset_n = 1'b1;
    tick();
    check_idle_load("post_reset");

    // Full memory: 20 words offered, no load_last, only 16 fit.
    for (int i = 0; i < 32; i++) stim[i] = $urandom;
    load_program(20, 1'b0, 1'b0);
    check("full_word_count", 32'(word_count), 32'd16);
    hold_and_run($urandom_range(5, 30), 1'b1, 1'b0);
    hold_done(3);
    do_restart();

    // Sum program with gaps, backpressure through HOLD/RUN, halt on cycle 40.
    for (int i = 0; i < 9; i++) stim[i] = sum_prog[i];
    load_program(9, 1'b1, 1'b1);
    check("sum_word_count", 32'(word_count), 32'd9);
    hold_and_run(40, 1'b1, 1'b0);
    for (int a = 0; a < int'(Depth); a++) begin
      fetch_addr = a;
      #1;
      check("done_mem_image", fetch_data, exp_fetch(fetch_addr));
    end
    hold_done(10);
    do_restart();

    // Async reset mid-load after 4 of 9 words.
    load_program(4, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    ref_wc    = 0;
    ref_cc    = 0;
    ref_fault = 1'b0;
    check_idle_load("async_reset");
    #4;
    reset_n = 1'b1;
    tick();
    check_idle_load("after_async");

    // Full reload, then an out-of-range fetch in RUN.
    load_program(9, 1'b1, 1'b1);
    hold_and_run($urandom_range(5, 50), 1'b0, 1'b1);
    hold_done(2);
    fetch_addr = 32'h0000_0103;
    #1;
    check("high_addr_fetch", fetch_data, exp_fetch(fetch_addr));
    check("final_fetch_fault", {31'd0, fetch_fault}, {31'd0, ref_fault});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
